// File: rtl/fmul_sched_if.sv
// Requester, response and status signals of the fmul_sched multiplier scheduler.
interface fmul_sched_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
);
  localparam int W = 1 + NEXP + NSIG;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_rm;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_rm;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_y;
  logic [4:0]   rsp_flags;
  logic         busy;
  logic [4:0]   fflags;
  logic         fflags_clr;

  modport master (
    output req0_valid, req0_a, req0_b, req0_rm,
    output req1_valid, req1_a, req1_b, req1_rm,
    output flush, rsp_ready, fflags_clr,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_flags, busy, fflags
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_rm,
    input  req1_valid, req1_a, req1_b, req1_rm,
    input  flush, rsp_ready, fflags_clr,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_flags, busy, fflags
  );
endinterface

// File: rtl/fmul_sched.sv
// Two-port round-robin scheduler around a combinational FP multiplier (fmul_core).
// Define FMUL_SCHED_STICKY_FLAGS_EN to accumulate sticky exception flags on fflags.
module fmul_core #(
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  localparam int W = 1 + NEXP + NSIG
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rm,
  output logic [W-1:0] y,
  output logic [4:0]   flags
);
  localparam int EW = NEXP + 3;
  localparam logic [EW-1:0] BIAS = {4'b0000, {(NEXP-1){1'b1}}};
  localparam logic [EW-1:0] EMAX = {3'b000, {NEXP{1'b1}}};

  logic            sa, sb, s;
  logic [NEXP-1:0] ea, eb;
  logic [NSIG-1:0] fa, fb, frac;
  logic            a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [2*NSIG+1:0] prod;
  logic            norm, guard, sticky, rnd;
  logic [NSIG:0]   frac_r;
  logic [EW-1:0]   exp_w;
  logic            ovf, udf;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign s      = sa ^ sb;
  assign a_max  = &ea;
  assign b_max  = &eb;
  // Subnormal operands and results are flushed to signed zero.
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_nan  = a_max & |fa;
  assign b_nan  = b_max & |fb;
  assign a_inf  = a_max & ~|fa;
  assign b_inf  = b_max & ~|fb;
  assign a_snan = a_nan & ~fa[NSIG-1];
  assign b_snan = b_nan & ~fb[NSIG-1];

  assign prod   = {{(NSIG+1){1'b0}}, 1'b1, fa} * {{(NSIG+1){1'b0}}, 1'b1, fb};
  assign norm   = prod[2*NSIG+1];
  assign frac   = norm ? prod[2*NSIG:NSIG+1] : prod[2*NSIG-1:NSIG];
  assign guard  = norm ? prod[NSIG] : prod[NSIG-1];
  assign sticky = norm ? |prod[NSIG-1:0] : |prod[NSIG-2:0];
  assign rnd    = rm & guard & (sticky | frac[0]);
  assign frac_r = {1'b0, frac} + {{NSIG{1'b0}}, rnd};
  // A rounding carry leaves frac_r[NSIG-1:0] zero, so only the exponent moves.
  assign exp_w  = {3'b000, ea} + {3'b000, eb} - BIAS
                + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, frac_r[NSIG]};
  assign ovf    = !exp_w[EW-1] && (exp_w >= EMAX);
  assign udf    = exp_w[EW-1] || (exp_w == '0);

  always_comb begin
    y     = '0;
    flags = '0;
    if (a_nan || b_nan) begin
      y        = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      flags[4] = a_snan | b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      y        = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      flags[4] = 1'b1;
    end else if (a_inf || b_inf) begin
      y = {s, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (a_zero || b_zero) begin
      y = {s, {(NEXP+NSIG){1'b0}}};
    end else if (ovf) begin
      y     = rm ? {s, {NEXP{1'b1}}, {NSIG{1'b0}}}
                 : {s, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
      flags = 5'b00101;
    end else if (udf) begin
      y     = {s, {(NEXP+NSIG){1'b0}}};
      flags = 5'b00011;
    end else begin
      y        = {s, exp_w[NEXP-1:0], frac_r[NSIG-1:0]};
      flags[0] = guard | sticky;
    end
  end
endmodule

module fmul_sched #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input logic         clk,
  input logic         rst_n,
  fmul_sched_if.slave bus
);
  localparam int W = 1 + NEXP + NSIG;

  logic         adv1, adv2, grant, accept, hs, last;
  logic         s1_valid, s1_id, s1_rm;
  logic [W-1:0] s1_a, s1_b;
  logic         s2_valid, s2_id;
  logic [W-1:0] s2_y;
  logic [4:0]   s2_flags;
  logic [W-1:0] core_y;
  logic [4:0]   core_flags;

  fmul_core #(.NEXP(NEXP), .NSIG(NSIG)) u_core (
    .a(s1_a), .b(s1_b), .rm(s1_rm), .y(core_y), .flags(core_flags)
  );

  always_comb begin
    adv2 = !s2_valid || bus.rsp_ready;
    adv1 = !s1_valid || adv2;
    if (bus.req0_valid && bus.req1_valid) grant = ~last;
    else                                  grant = bus.req1_valid;
    bus.req0_ready = adv1 && !grant && !bus.flush;
    bus.req1_ready = adv1 && grant && !bus.flush;
    accept = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
    hs     = s2_valid && bus.rsp_ready && !bus.flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_rm    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_y     <= '0;
      s2_flags <= '0;
      last     <= 1'b1;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id    <= s1_id;
          s2_y     <= core_y;
          s2_flags <= core_flags;
        end
      end
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_id <= grant;
          s1_a  <= grant ? bus.req1_a  : bus.req0_a;
          s1_b  <= grant ? bus.req1_b  : bus.req0_b;
          s1_rm <= grant ? bus.req1_rm : bus.req0_rm;
          last  <= grant;
        end
      end
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_y     = s2_y;
  assign bus.rsp_flags = s2_flags;
  assign bus.busy      = s1_valid | s2_valid;

`ifdef FMUL_SCHED_STICKY_FLAGS_EN
  logic [4:0] fflags_q;

  // Clear wins first, so a simultaneous handshake leaves only the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fflags_q <= '0;
    else if (bus.fflags_clr) fflags_q <= hs ? s2_flags : '0;
    else if (hs)             fflags_q <= fflags_q | s2_flags;
  end

  assign bus.fflags = fflags_q;
`else
  logic unused_sticky;

  assign unused_sticky = bus.fflags_clr ^ hs;
  assign bus.fflags    = '0;
`endif
endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched: arbitration, latency, backpressure, exceptions, flush, reset.
module tb_fmul_sched;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  fmul_sched_if #(.NEXP(8), .NSIG(23)) bus ();

  fmul_sched #(.NEXP(8), .NSIG(23)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef FMUL_SCHED_STICKY_FLAGS_EN
  localparam logic [4:0] EXP_FF = 5'b10101;
`else
  localparam logic [4:0] EXP_FF = 5'b00000;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_rm = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_rm = 1'b0;
    bus.flush      = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.fflags_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_y !== 32'h0) $display("FAIL reset_rsp_y: got %h want 0", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b0) $display("FAIL reset_rsp_flags: got %b want 0", bus.rsp_flags); else n_pass++;
    n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.fflags !== 5'b0) $display("FAIL reset_fflags: got %b want 0", bus.fflags); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_contention();
    logic [31:0] ry [8];
    logic        rid[8];
    int          rc [8];
    int          nr = 0;
    bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000; bus.req0_rm = 1'b1;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000; bus.req1_rm = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.req0_valid = (cyc < 4);
      bus.req1_valid = (cyc < 4);
      #1;
      if (cyc < 4) begin
        n_checks++; if (bus.req0_ready !== (cyc % 2 == 0)) $display("FAIL cont_ready0 cyc%0d: got %b want %b", cyc, bus.req0_ready, (cyc % 2 == 0)); else n_pass++;
        n_checks++; if (bus.req1_ready !== (cyc % 2 == 1)) $display("FAIL cont_ready1 cyc%0d: got %b want %b", cyc, bus.req1_ready, (cyc % 2 == 1)); else n_pass++;
      end
      if (bus.rsp_valid === 1'b1 && nr < 8) begin
        ry[nr] = bus.rsp_y; rid[nr] = bus.rsp_id; rc[nr] = cyc; nr++;
      end
      step();
    end
    n_checks++; if (nr !== 4) $display("FAIL cont_count: got %0d want 4", nr); else n_pass++;
    for (int k = 0; k < nr; k++) begin
      n_checks++; if (rid[k] !== (k % 2 == 1)) $display("FAIL cont_id[%0d]: got %b want %b", k, rid[k], (k % 2 == 1)); else n_pass++;
      n_checks++; if (ry[k] !== ((k % 2 == 1) ? 32'h40800000 : 32'h40400000)) $display("FAIL cont_y[%0d]: got %h want %h", k, ry[k], ((k % 2 == 1) ? 32'h40800000 : 32'h40400000)); else n_pass++;
      n_checks++; if (rc[k] !== k + 2) $display("FAIL cont_cycle[%0d]: got %0d want %0d", k, rc[k], k + 2); else n_pass++;
    end
    idle();
  endtask

  task automatic test_single();
    idle();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000; bus.req0_rm = 1'b1;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.req0_ready); else n_pass++;
    step();
    bus.req0_valid = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_s1: got %b want 1", bus.busy); else n_pass++;
    step();
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_y !== 32'h40400000) $display("FAIL single_y: got %h want 40400000", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b0) $display("FAIL single_flags: got %b want 00000", bus.rsp_flags); else n_pass++;
    n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL single_id: got %b want 0", bus.rsp_id); else n_pass++;
    step();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_consumed: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_idle: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] bt[4];
    logic [31:0] yt[4];
    logic [31:0] ry[8];
    int          k = 0, nr = 0, maxfl = 0;
    logic        acc;
    bt[0] = 32'h3F800000; bt[1] = 32'h40000000; bt[2] = 32'h40400000; bt[3] = 32'h40800000;
    yt[0] = 32'h40000000; yt[1] = 32'h40800000; yt[2] = 32'h40C00000; yt[3] = 32'h41000000;
    idle();
    bus.req1_a = 32'h40000000; bus.req1_rm = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.rsp_ready  = !(cyc >= 2 && cyc <= 4);
      bus.req1_valid = (k < 4);
      bus.req1_b     = bt[k % 4];
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++; if (bus.req1_ready !== 1'b0) $display("FAIL bp_ready cyc%0d: got %b want 0", cyc, bus.req1_ready); else n_pass++;
        n_checks++; if (bus.rsp_y !== yt[0]) $display("FAIL bp_hold_y cyc%0d: got %h want %h", cyc, bus.rsp_y, yt[0]); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_hold_valid cyc%0d: got %b want 1", cyc, bus.rsp_valid); else n_pass++;
      end
      acc = bus.req1_valid && bus.req1_ready;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready && nr < 8) begin
        ry[nr] = bus.rsp_y; nr++;
      end
      step();
      if (acc) k++;
      if (k - nr > maxfl) maxfl = k - nr;
    end
    n_checks++; if (maxfl !== 2) $display("FAIL bp_inflight: got %0d want 2", maxfl); else n_pass++;
    n_checks++; if (nr !== 4) $display("FAIL bp_count: got %0d want 4", nr); else n_pass++;
    for (int j = 0; j < nr && j < 4; j++) begin
      n_checks++; if (ry[j] !== yt[j]) $display("FAIL bp_y[%0d]: got %h want %h", j, ry[j], yt[j]); else n_pass++;
    end
    idle();
  endtask

  task automatic test_exceptions();
    idle();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h7F800000; bus.req0_b = 32'h00000000; bus.req0_rm = 1'b1;
    step();
    bus.req0_a = 32'h7F000000; bus.req0_b = 32'h7F000000; bus.req0_rm = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    #1;
    n_checks++; if (bus.rsp_y !== 32'h7FC00000) $display("FAIL exc_nan_y: got %h want 7fc00000", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b10000) $display("FAIL exc_nan_flags: got %b want 10000", bus.rsp_flags); else n_pass++;
    step();
    n_checks++; if (bus.rsp_y !== 32'h7F800000) $display("FAIL exc_ovf_y: got %h want 7f800000", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b00101) $display("FAIL exc_ovf_flags: got %b want 00101", bus.rsp_flags); else n_pass++;
    step();
    n_checks++; if (bus.fflags !== EXP_FF) $display("FAIL exc_fflags: got %b want %b", bus.fflags, EXP_FF); else n_pass++;
    bus.fflags_clr = 1'b1;
    step();
    bus.fflags_clr = 1'b0;
    n_checks++; if (bus.fflags !== 5'b0) $display("FAIL exc_fflags_clr: got %b want 00000", bus.fflags); else n_pass++;
  endtask

  task automatic test_flush();
    int late = 0;
    idle();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h7F000000; bus.req0_b = 32'h7F000000; bus.req0_rm = 1'b1;
    step();
    bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000;
    step();
    bus.req0_a = 32'h40000000; bus.req0_b = 32'h40000000;
    bus.flush  = 1'b1;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.req0_ready); else n_pass++;
    step();
    bus.flush = 1'b0; bus.req0_valid = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", bus.busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.rsp_valid === 1'b1) late++;
    end
    n_checks++; if (late !== 0) $display("FAIL flush_late_rsp: got %0d want 0", late); else n_pass++;
    n_checks++; if (bus.fflags !== 5'b0) $display("FAIL flush_fflags: got %b want 00000", bus.fflags); else n_pass++;
  endtask

  task automatic test_reset_mid();
    idle();
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h7F000000; bus.req1_b = 32'h7F000000; bus.req1_rm = 1'b1;
    step();
    bus.req1_a = 32'h3FC00000; bus.req1_b = 32'h40000000;
    step();
    bus.req1_valid = 1'b0;
    #1;
    n_checks++; if (bus.rsp_id !== 1'b1) $display("FAIL rmid_pre_id: got %b want 1", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b00101) $display("FAIL rmid_pre_flags: got %b want 00101", bus.rsp_flags); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL rmid_id: got %b want 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_y !== 32'h0) $display("FAIL rmid_y: got %h want 0", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.rsp_flags !== 5'b0) $display("FAIL rmid_flags: got %b want 0", bus.rsp_flags); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.fflags !== 5'b0) $display("FAIL rmid_fflags: got %b want 0", bus.fflags); else n_pass++;
    step();
    rst_n = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000; bus.req0_rm = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000; bus.req1_rm = 1'b0;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) $display("FAIL rmid_first_ready0: got %b want 1", bus.req0_ready); else n_pass++;
    n_checks++; if (bus.req1_ready !== 1'b0) $display("FAIL rmid_first_ready1: got %b want 0", bus.req1_ready); else n_pass++;
    step();
    n_checks++; if (bus.req1_ready !== 1'b1) $display("FAIL rmid_second_ready1: got %b want 1", bus.req1_ready); else n_pass++;
    n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL rmid_second_ready0: got %b want 0", bus.req0_ready); else n_pass++;
    idle();
    step();
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_exceptions();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d of %0d passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
